sd_wp_debounce: RTL

SD_WP_DEBOUNCE -- requirements
Module: sd_wp_debounce

---
 rtl/sd_wp_debounce.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sd_wp_debounce.sv
// SD write-protect switch synchronizer and debouncer with an Avalon-MM status port.
// Define SD_WP_IRQ_EN to build in the edge-capture, mask and interrupt registers.
module sd_wp_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wp_pin_in,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        wp_clean,
    output logic        irq
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {StStable, StCount} state_e;

    state_e           state_q, state_d;
    logic [1:0]       sync_q;
    logic             wp_sync;
    logic [CNT_W-1:0] cnt_q;
    logic             wp_clean_q;
    logic             differ, cnt_last;
    logic             in_count, accept, rise_pulse, fall_pulse;
    logic [1:0]       capture, mask;
    logic [31:0]      rd_d;

    assign wp_sync  = sync_q[1];
    assign wp_clean = wp_clean_q;
    assign differ   = wp_sync != wp_clean_q;
    assign cnt_last = cnt_q == CNT_LAST;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], wp_pin_in};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StStable;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStable: if (differ) state_d = StCount;
            StCount:  if (!differ || cnt_last) state_d = StStable;
            default:  state_d = StStable;
        endcase
    end

    always_comb begin
        in_count   = state_q == StCount;
        accept     = in_count && differ && cnt_last;
        rise_pulse = accept && wp_sync;
        fall_pulse = accept && !wp_sync;
    end

    // Counter saturates at CNT_LAST: acceptance leaves COUNT on that same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            wp_clean_q <= 1'b0;
        end else begin
            if (state_q == StStable) begin
                if (differ) cnt_q <= '0;
            end else if (differ && !cnt_last) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (accept) wp_clean_q <= wp_sync;
        end
    end

`ifdef SD_WP_IRQ_EN
    logic       wr;
    logic [1:0] capture_q, capture_d, mask_q;
    logic       irq_q;
    logic       unused_wdata;

    assign wr           = chipselect && !write_n;
    assign unused_wdata = ^writedata[31:2];

    // Clear first, then set, so a coincident edge pulse wins over a W1C.
    always_comb begin
        capture_d = capture_q;
        if (wr && address == 2'd1) capture_d = capture_d & ~writedata[1:0];
        capture_d = capture_d | {fall_pulse, rise_pulse};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capture_q <= 2'b00;
            mask_q    <= 2'b00;
            irq_q     <= 1'b0;
        end else begin
            capture_q <= capture_d;
            if (wr && address == 2'd2) mask_q <= writedata[1:0];
            irq_q <= |(capture_q & mask_q);
        end
    end

    assign capture = capture_q;
    assign mask    = mask_q;
    assign irq     = irq_q;
`else
    logic unused_bus;

    assign unused_bus = ^{writedata, chipselect, write_n, rise_pulse, fall_pulse};
    assign capture    = 2'b00;
    assign mask       = 2'b00;
    assign irq        = 1'b0;
`endif

    always_comb begin
        rd_d = '0;
        unique case (address)
            2'd0: rd_d[1:0] = {wp_sync, wp_clean_q};
            2'd1: rd_d[1:0] = capture;
            2'd2: rd_d[1:0] = mask;
            2'd3: rd_d[0]   = in_count;
            default: rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_d;
        end
    end

endmodule
